// File: rtl/serial_shift_ctrl_if.sv
// Request/response bundle for serial_shift_ctrl: decoded instruction fields in,
// busy/done/result back to the execute stage.
interface serial_shift_ctrl_if;
    logic        start;
    logic        flush;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm_out;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic        busy;
    logic        done;
    logic [31:0] result;

    modport master (
        output start, flush, rs1, rs2, imm_out, opcode, func3, func7,
        input  busy, done, result
    );

    modport slave (
        input  start, flush, rs1, rs2, imm_out, opcode, func3, func7,
        output busy, done, result
    );
endinterface

// File: rtl/serial_shift_ctrl.sv
// Multi-cycle SLL/SRL/SRA unit (IDLE -> SHIFT -> DONE).
// Define SHIFT_FAST_STEP_EN to shift up to 4 bits per cycle instead of 1.
module serial_shift_ctrl (
    input  logic          clk,
    input  logic          rst,
    serial_shift_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_SLL = 2'd0,
        OP_SRL = 2'd1,
        OP_SRA = 2'd2,
        OP_ILL = 2'd3
    } op_t;

    localparam logic [6:0] OPC_R = 7'b0110011;
    localparam logic [6:0] OPC_I = 7'b0010011;

    state_t      state_r;
    op_t         op_r;
    logic [31:0] work_r;
    logic [4:0]  count_r;
    logic        busy_r;
    logic        done_r;
    logic [31:0] result_r;

    op_t         dec_op_s;
    logic [4:0]  shamt_s;
    logic [4:0]  step_s;
    logic [31:0] shifted_s;
    logic        unused_bits_s;

    // Decode the requested shift from opcode/func3/funct; anything else is illegal.
    function automatic op_t decode_op(
        input logic [6:0]  opcode,
        input logic [2:0]  func3,
        input logic [6:0]  func7,
        input logic [31:0] imm
    );
        logic [6:0] funct;
        logic       opc_ok;
        op_t        op;
        case (opcode)
            OPC_R: begin
                funct  = func7;
                opc_ok = 1'b1;
            end
            OPC_I: begin
                funct  = imm[11:5];
                opc_ok = 1'b1;
            end
            default: begin
                funct  = 7'd0;
                opc_ok = 1'b0;
            end
        endcase
        if (opc_ok) begin
            case ({func3, funct})
                {3'b001, 7'b0000000}: op = OP_SLL;
                {3'b101, 7'b0000000}: op = OP_SRL;
                {3'b101, 7'b0100000}: op = OP_SRA;
                default:              op = OP_ILL;
            endcase
        end else begin
            op = OP_ILL;
        end
        return op;
    endfunction

    // Bits moved per SHIFT cycle; never larger than the remaining count.
    function automatic logic [4:0] step_of(input logic [4:0] count);
`ifdef SHIFT_FAST_STEP_EN
        if (count > 5'd4) begin
            return 5'd4;
        end else begin
            return count;
        end
`else
        if (count != 5'd0) begin
            return 5'd1;
        end else begin
            return 5'd0;
        end
`endif
    endfunction

    // Request decode and shift amount selection.
    always_comb begin
        dec_op_s = decode_op(bus.opcode, bus.func3, bus.func7, bus.imm_out);
        if (bus.opcode == OPC_R) begin
            shamt_s = bus.rs2[4:0];
        end else begin
            shamt_s = bus.imm_out[4:0];
        end
    end

    // One shift step of the working register according to the latched op.
    always_comb begin
        step_s = step_of(count_r);
        case (op_r)
            OP_SLL:  shifted_s = work_r << step_s;
            OP_SRL:  shifted_s = work_r >> step_s;
            OP_SRA:  shifted_s = $unsigned($signed(work_r) >>> step_s);
            default: shifted_s = work_r;
        endcase
    end

    assign unused_bits_s = ^{bus.rs2[31:5], bus.imm_out[31:12]};

    // Control FSM with registered busy/done/result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            op_r     <= OP_ILL;
            work_r   <= 32'h0;
            count_r  <= 5'd0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            result_r <= 32'h0;
        end else if (bus.flush) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    // The done cycle still closes the previous operation, so start is not taken then.
                    if (bus.start && !done_r) begin
                        work_r  <= bus.rs1;
                        op_r    <= dec_op_s;
                        count_r <= shamt_s;
                        busy_r  <= 1'b1;
                        if ((dec_op_s != OP_ILL) && (shamt_s != 5'd0)) begin
                            state_r <= ST_SHIFT;
                        end else begin
                            state_r <= ST_DONE;
                        end
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b1;
                    work_r  <= shifted_s;
                    count_r <= count_r - step_s;
                    if (count_r == step_s) begin
                        state_r <= ST_DONE;
                    end else begin
                        state_r <= ST_SHIFT;
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                    if (op_r == OP_ILL) begin
                        result_r <= 32'h0;
                    end else begin
                        result_r <= work_r;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.result = result_r;

endmodule
